// File: rtl/memtest_reporter.sv
// memtest_reporter: serves per-channel port-tester statistics over the req/wr/ack debug bridge.
// Stall detection is built only when MEMTEST_STALL_DETECT_EN is defined.
module memtest_reporter #(
    parameter int CHANNELS     = 5,
    parameter int STALL_BITS   = 20,
    parameter int RESET_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_in,
    input  logic [32*CHANNELS-1:0]  ch_readcount,
    input  logic [32*CHANNELS-1:0]  ch_errorcount,
    input  logic [16*CHANNELS-1:0]  ch_errbits,
    output logic                    test_reset_n,
    output logic [CHANNELS-1:0]     ch_enable,
    output logic [CHANNELS-1:0]     ch_stall,
    output logic                    br_req,
    output logic                    br_wr,
    output logic [31:0]             br_d,
    input  logic [31:0]             br_q,
    input  logic                    br_ack
);
    typedef enum logic [2:0] {CMD, WAIT, DECODE, SEND1, SEND2, RST} state_t;
    state_t state, nxt;
    logic [7:0] op;
    logic [7:0] rst_cnt;
    logic [15:0] arg;
    logic legacy;
    logic do_rst;
    logic [31:0] w0, w1, w2;
    logic [31:0] status;
    logic [31:0] rd_w [256];
    logic [31:0] er_w [256];
    logic [31:0] eb_w [256];
    // Full 256-entry view so any 8-bit index selects a word; absent channels read all ones.
    for (genvar i = 0; i < 256; i++) begin : g_ch
        if (i < CHANNELS) begin : g_in
            assign rd_w[i] = ch_readcount[32*i +: 32];
            assign er_w[i] = ch_errorcount[32*i +: 32];
            assign eb_w[i] = {15'b0, ch_stall[i], ch_errbits[16*i +: 16]};
        end else begin : g_out
            assign rd_w[i] = '1;
            assign er_w[i] = '1;
            assign eb_w[i] = '1;
        end
    end
    assign do_rst = op == 8'h01 || (op == 8'h00 && legacy);
    assign status = {8'(CHANNELS), 8'h00, 16'(ch_stall)};
    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state        <= CMD;
            nxt          <= CMD;
            br_req       <= 1'b0;
            br_wr        <= 1'b0;
            br_d         <= '0;
            test_reset_n <= 1'b1;
            ch_enable    <= '1;
            op           <= '0;
            arg          <= '0;
            legacy       <= 1'b0;
            rst_cnt      <= '0;
            w0           <= '0;
            w1           <= '0;
            w2           <= '0;
        end else begin
            case (state)
                CMD: begin
                    br_req <= 1'b1;
                    br_wr  <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: if (br_ack) begin
                    br_req <= 1'b0;
                    state  <= br_wr ? nxt : DECODE;
                    if (!br_wr) begin
                        op     <= br_q[31:24];
                        arg    <= br_q[23:8];
                        legacy <= br_q[7:0] == 8'hFF;
                        w0     <= rd_w[br_q[7:0]];
                        w1     <= er_w[br_q[7:0]];
                        w2     <= eb_w[br_q[7:0]];
                    end
                end
                // DECODE also launches the first reply word so it is requested two cycles after the command ack.
                DECODE: if (do_rst) begin
                    test_reset_n <= 1'b0;
                    rst_cnt      <= 8'(RESET_CYCLES - 1);
                    state        <= RST;
                end else begin
                    br_req <= 1'b1;
                    br_wr  <= 1'b1;
                    state  <= WAIT;
                    nxt    <= op == 8'h00 ? SEND1 : CMD;
                    br_d   <= op == 8'h00 ? w0 :
                              op == 8'h02 ? 32'(arg[CHANNELS-1:0]) :
                              op == 8'h03 ? status : 32'h0000DEAD;
                    if (op == 8'h02)
                        ch_enable <= arg[CHANNELS-1:0];
                end
                SEND1: begin
                    br_d   <= w1;
                    br_req <= 1'b1;
                    br_wr  <= 1'b1;
                    nxt    <= SEND2;
                    state  <= WAIT;
                end
                SEND2: begin
                    br_d   <= w2;
                    br_req <= 1'b1;
                    br_wr  <= 1'b1;
                    nxt    <= CMD;
                    state  <= WAIT;
                end
                RST: if (rst_cnt == 8'd0) begin
                    test_reset_n <= 1'b1;
                    state        <= CMD;
                end else begin
                    rst_cnt <= rst_cnt - 8'd1;
                end
                default: state <= CMD;
            endcase
        end
    end
`ifdef MEMTEST_STALL_DETECT_EN
    logic clr_stall;
    assign clr_stall = state == DECODE && do_rst;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_stall
        logic [STALL_BITS-1:0] timer;
        logic [31:0] last_rc;
        logic flag;
        assign ch_stall[i] = flag;
        always_ff @(posedge clk or negedge reset_in) begin
            if (!reset_in) begin
                timer   <= '0;
                last_rc <= '0;
                flag    <= 1'b0;
            end else begin
                last_rc <= ch_readcount[32*i +: 32];
                if (clr_stall) begin
                    timer <= '0;
                    flag  <= 1'b0;
                end else if (ch_readcount[32*i +: 32] != last_rc || !ch_enable[i] || !test_reset_n) begin
                    timer <= '0;
                end else if (timer != '1) begin
                    timer <= timer + 1'b1;
                    if (&(timer + 1'b1))
                        flag <= 1'b1;
                end
            end
        end
    end
`else
    assign ch_stall = '0;
`endif
endmodule

// File: tb/tb_memtest_reporter.sv
// tb_memtest_reporter: bridge host model with a reply scoreboard for memtest_reporter.
module tb_memtest_reporter;
    localparam int CH = 5;
`ifdef MEMTEST_STALL_DETECT_EN
    localparam logic STALL_ON = 1'b1;
`else
    localparam logic STALL_ON = 1'b0;
`endif
    logic clk = 1'b0;
    logic reset_in = 1'b1;
    logic [32*CH-1:0] rc_base = '0;
    logic [32*CH-1:0] ch_readcount;
    logic [32*CH-1:0] ch_errorcount = '0;
    logic [16*CH-1:0] ch_errbits = '0;
    logic [31:0] rc1 = '0;
    logic run1 = 1'b1;
    logic test_reset_n, br_req, br_wr;
    logic br_ack = 1'b0;
    logic [CH-1:0] ch_enable, ch_stall;
    logic [31:0] br_d;
    logic [31:0] br_q = '0;
    int n_chk = 0, n_bad = 0, cyc = 0;
    int dly = 0, wdly = 0, ack_cyc = 0;
    logic first = 1'b0;
    logic hold = 1'b0;
    logic [31:0] cmd_q[$];
    logic [31:0] exp_q[$];

    memtest_reporter #(.CHANNELS(CH), .STALL_BITS(4), .RESET_CYCLES(16)) dut (
        .clk(clk), .reset_in(reset_in),
        .ch_readcount(ch_readcount), .ch_errorcount(ch_errorcount), .ch_errbits(ch_errbits),
        .test_reset_n(test_reset_n), .ch_enable(ch_enable), .ch_stall(ch_stall),
        .br_req(br_req), .br_wr(br_wr), .br_d(br_d), .br_q(br_q), .br_ack(br_ack)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (run1) rc1 <= rc1 + 1;
    always_comb begin
        ch_readcount = rc_base;
        ch_readcount[63:32] = rc1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Host side of the bridge: hands out queued commands and scores every write.
    initial begin
        forever begin
            @(negedge clk);
            if (br_ack) br_ack = 1'b0;
            else if (reset_in && br_req && !br_wr && cmd_q.size() > 0) begin
                br_q = cmd_q.pop_front();
                br_ack = 1'b1;
                ack_cyc = cyc;
                first = 1'b1;
            end else if (reset_in && br_req && br_wr && !(hold && exp_q.size() == 0)) begin
                if (first) begin
                    chk("reply_latency", cyc - ack_cyc, 2);
                    first = 1'b0;
                end
                if (dly < wdly) dly++;
                else begin
                    chk("reply_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) chk("reply_data", br_d, exp_q.pop_front());
                    br_ack = 1'b1;
                    dly = 0;
                    wdly = 1 - wdly;
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk); #1;
        while (n < 300 && !(cmd_q.size() == 0 && exp_q.size() == 0 && br_req && !br_wr && !br_ack)) begin
            @(negedge clk); #1;
            n++;
        end
        chk(name, 32'(n < 300), 1);
    endtask

    task automatic rst_pulse(input string name);
        int n = 0, low = 0;
        while (n < 50 && test_reset_n) begin @(negedge clk); n++; end
        while (low < 300 && !test_reset_n) begin @(negedge clk); low++; end
        chk(name, low, 16);
    endtask

    task automatic next_is_read(input string name);
        int n = 0;
        while (n < 20 && !br_req) begin @(negedge clk); #1; n++; end
        chk({name, "_seen"}, 32'(br_req), 1);
        chk(name, 32'(br_wr), 0);
    endtask

    initial begin
        int n;
        rc_base[95:64] = 32'h1234;
        ch_errorcount[95:64] = 32'd5;
        ch_errbits[47:32] = 16'h0010;
        #1 reset_in = 1'b0;
        #2;
        chk("rst_br_req", 32'(br_req), 0);
        chk("rst_br_wr", 32'(br_wr), 0);
        chk("rst_br_d", br_d, 0);
        chk("rst_test_reset_n", 32'(test_reset_n), 1);
        chk("rst_ch_enable", 32'(ch_enable), 32'h1F);
        chk("rst_ch_stall", 32'(ch_stall), 0);
        repeat (2) @(negedge clk);
        reset_in = 1'b1;

        exp_q.push_back(32'h00001234); exp_q.push_back(32'h5); exp_q.push_back(32'h10);
        cmd_q.push_back(32'h00000002);
        wait_idle("idle_report_ch2");

        cmd_q.push_back(32'h000000FF);
        rst_pulse("legacy_reset_len");
        next_is_read("legacy_next_read");

        exp_q.push_back(32'h00000005);
        cmd_q.push_back(32'h02000500);
        wait_idle("idle_set_enable");
        chk("enable_mask", 32'(ch_enable), 32'h05);

        repeat (3) exp_q.push_back(32'hFFFFFFFF);
        exp_q.push_back(32'h0000DEAD);
        cmd_q.push_back(32'h00000009);
        cmd_q.push_back(32'h7F000000);
        wait_idle("idle_oor_unknown");

        rc_base[31:0] = 32'hAAAA0001;
        ch_errorcount[31:0] = 32'h22;
        ch_errbits[15:0] = 16'h8001;
        cmd_q.push_back(32'h01000000);
        rst_pulse("reset_all_len");
        exp_q.push_back(32'hAAAA0001); exp_q.push_back(32'h22); exp_q.push_back(32'h00008001);
        cmd_q.push_back(32'h00000000);
        n = 0;
        while (n < 100 && exp_q.size() > 2) begin @(negedge clk); #1; n++; end
        chk("coherence_word0_done", 32'(exp_q.size()), 2);
        rc_base[31:0] = 32'h0;
        ch_errorcount[31:0] = 32'h0;
        ch_errbits[15:0] = 16'h7777;
        wait_idle("idle_coherence");

        hold = 1'b1;
        rc_base[127:96] = 32'h3333;
        ch_errorcount[127:96] = 32'h5555;
        exp_q.push_back(32'h3333);
        cmd_q.push_back(32'h00000003);
        n = 0;
        while (n < 100 && !(exp_q.size() == 0 && br_req && br_wr)) begin @(negedge clk); #1; n++; end
        chk("send1_reached", 32'(n < 100), 1);
        #2 reset_in = 1'b0;
        #1;
        chk("midrst_br_req", 32'(br_req), 0);
        chk("midrst_br_wr", 32'(br_wr), 0);
        chk("midrst_br_d", br_d, 0);
        chk("midrst_enable", 32'(ch_enable), 32'h1F);
        chk("midrst_test_reset_n", 32'(test_reset_n), 1);
        @(negedge clk);
        reset_in = 1'b1;
        hold = 1'b0;
        next_is_read("post_reset_read");

        exp_q.push_back(32'h00000002);
        cmd_q.push_back(32'h02000200);
        wait_idle("idle_enable_ch1");
        chk("enable_ch1_only", 32'(ch_enable), 32'h02);
        @(posedge clk);
        #1 run1 = 1'b0;
        repeat (15) @(posedge clk);
        #1 chk("stall_not_yet", 32'(ch_stall), 0);
        @(posedge clk);
        #1 chk("stall_rise", 32'(ch_stall), STALL_ON ? 32'h02 : 32'h0);
        exp_q.push_back(STALL_ON ? 32'h05000002 : 32'h05000000);
        cmd_q.push_back(32'h03000000);
        wait_idle("idle_status");
        cmd_q.push_back(32'h01000000);
        rst_pulse("clear_reset_len");
        chk("stall_cleared", 32'(ch_stall), 0);
        run1 = 1'b1;
        wait_idle("idle_end");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/memtest_reporter.md
# memtest_reporter

Parametrised host-reporting controller for the SDRAM port-test harness. It collects per-channel statistics from CHANNELS port testers and serves them over the 32-bit req/wr/ack debug-bridge handshake. It also drives the testers' shared reset and per-channel enables, and flags channels whose read counter has stopped advancing. It replaces the fixed five-port JTAG report loop in the test top level.

## Interface

Parameters:
- CHANNELS, 5, number of port testers monitored (1..16).
- STALL_BITS, 20, width of the per-channel stall timer; a stall is flagged after 2^STALL_BITS-1 idle cycles.
- RESET_CYCLES, 16, length of the test_reset_n low pulse (1..255).

Ports:
- clk  in  1  system clock.
- reset_in  in  1  reset, asynchronous, active-low.
- ch_readcount  in  32*CHANNELS  packed; channel i at [32i+31:32i].
- ch_errorcount  in  32*CHANNELS  packed, same layout.
- ch_errbits  in  16*CHANNELS  packed; channel i at [16i+15:16i].
- test_reset_n  out  1  active-low reset to all testers.
- ch_enable  out  CHANNELS  per-tester run enable.
- ch_stall  out  CHANNELS  sticky stall flags.
- br_req  out  1  bridge request.
- br_wr  out  1  1 = write br_d to host, 0 = read command.
- br_d  out  32  data to host.
- br_q  in  32  command from host; valid when br_ack=1.
- br_ack  in  1  single-cycle bridge acknowledge.

## Operation

- Reset values:
  - br_req=0, br_wr=0, br_d=0.
  - test_reset_n=1.
  - ch_enable=all ones.
  - ch_stall=0.
  - state=CMD.
- States:
  - CMD: br_req=1, br_wr=0, go to WAIT.
  - WAIT: hold the request until br_ack. On ack, drop br_req and go to DECODE (command) or the next SEND/CMD.
  - DECODE: dispatch on the command.
  - SEND0, SEND1, SEND2: each loads br_d, sets br_req=1 and br_wr=1, then goes to WAIT.
  - RST: hold test_reset_n low, then return to CMD.
- Command word: opcode = br_q[31:24], index = br_q[7:0], arg = br_q[23:8].
- Opcode 0x00 REPORT:
  - On the ack edge, snapshot readcount, errorcount and errbits of channel `index` into holding registers.
  - SEND0 = readcount, SEND1 = errorcount, SEND2 = {15'b0, ch_stall[index], errbits}.
- Legacy command: if br_q[7:0]==8'hFF with opcode 0x00, treat it as RESET_ALL (compatible with existing host scripts).
- Out-of-range index (index ≥ CHANNELS, other than 0xFF): all three words are 32'hFFFFFFFF.
- Opcode 0x01 RESET_ALL: enter RST. Clears all ch_stall and all stall timers. Sends no reply.
- Opcode 0x02 SET_ENABLE: ch_enable ← arg[CHANNELS-1:0]. Reply (SEND0 only) = {16'b0, new mask zero-extended}.
- Opcode 0x03 STATUS: single reply word.
  - [31:24] = CHANNELS.
  - [23:16] = 0.
  - [15:0] = ch_stall zero-extended.
- Unknown opcode: single reply of 32'h0000DEAD.
- Stall timer, per channel (only when STALL detection is compiled in):
  - Resets to 0 whenever ch_readcount changes, when ch_enable[i]=0, or while test_reset_n=0.
  - Otherwise increments by 1 and saturates at all ones.
  - Reaching all ones sets ch_stall[i], which stays set until RESET_ALL or reset_in.

## Timing

- Command capture: the snapshot and decode use br_q on the br_ack cycle. DECODE occupies the following cycle. The first reply has br_req=1 two cycles after the command ack.
- br_req stays asserted until br_ack. It is deasserted on the cycle after ack and is low for at least one cycle between transactions.
- br_d is stable for the whole time br_req=1.
- RST: test_reset_n goes low the cycle after DECODE and stays low for exactly RESET_CYCLES cycles. CMD is re-entered on the following cycle.
- Snapshot coherence: all three report words reflect the same clock edge, even if the counters change during the reply.
- reset_in asserted mid-transaction: everything returns to reset values immediately (asynchronously). No partial reply is resumed.
- A stall flag rises 2^STALL_BITS-1 cycles after the last readcount change.

## Configuration

- MEMTEST_STALL_DETECT_EN defined: the stall timers and the ch_stall logic are built as described above.
- MEMTEST_STALL_DETECT_EN undefined:
  - No timers are built and ch_stall is tied to 0.
  - REPORT word 2 bit 16 and the STATUS [15:0] field read 0.
  - All other behaviour is unchanged.

## Test plan

- Reset, then bridge acks the CMD read with 0x00000002 while ch2 readcount=0x1234, errorcount=5, errbits=0x0010 → three writes: 0x00001234, 0x00000005, 0x00000010.
- Command 0x000000FF → no reply; test_reset_n low for exactly 16 cycles; next br_req has br_wr=0.
- Command 0x02000500 (arg=0x0005), CHANNELS=5 → ch_enable=5'b00101; reply 0x00000005.
- Command 0x00000009 with CHANNELS=5 → three writes of 0xFFFFFFFF. Command 0x7F000000 → one write of 0x0000DEAD.
- With MEMTEST_STALL_DETECT_EN and STALL_BITS=4:
  - Freeze ch1 readcount → ch_stall[1] rises 15 cycles later.
  - STATUS reply = 0x05000002.
  - RESET_ALL clears it.
- Change ch0 counters during SEND1 of a REPORT → SEND2 still carries the snapshot errbits. Drop reset_in during SEND1 → br_req=0 immediately.
